// File: rtl/input_loader_if.sv
// -----------------------------------------------------------------------------
// input_loader_if
// Valid/ready pixel stream feeding input_loader.
//   in_valid : source has a sample (in_data, in_last) this cycle
//   in_ready : loader can accept a sample this cycle
//   in_data  : unsigned pixel sample, PIXEL_WIDTH bits
//   in_last  : marks the final sample of a frame
// Modports: master = pixel source, slave = input_loader.
// -----------------------------------------------------------------------------
interface input_loader_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [PIXEL_WIDTH-1:0] in_data;
  logic                   in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/input_loader.sv
// -----------------------------------------------------------------------------
// input_loader
// Collects a serial stream of unsigned pixels, converts each to unsigned-valued
// signed fixed point (pixel p -> p / 2^PIXEL_WIDTH), assembles NUM_INPUTS of them
// into a parallel frame, pulses inputs_ready and holds the frame until done.
//
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   in_if         : input_loader_if.slave pixel stream (valid/ready/data/last)
//   inputs        : assembled frame; word i is inputs[i], each word is
//                   INTEGER_WIDTH+FRACTION_WIDTH bits with the binary point
//                   between bit FRACTION_WIDTH and bit FRACTION_WIDTH-1
//   inputs_ready  : one-cycle pulse, frame complete and valid
//   done          : downstream has finished with the current frame
//   busy          : frame presented and awaiting done
//   frame_error   : one-cycle pulse, in_last misaligned, frame discarded
//
// Optional build macro: INPUT_LOADER_DOUBLE_BUFFER_EN
//   Adds a second bank so the next frame can be collected while the current
//   one is presented. Undefined: single bank.
// -----------------------------------------------------------------------------
module input_loader #(
  parameter int NUM_INPUTS     = 16,
  parameter int PIXEL_WIDTH    = 8,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8
) (
  input  logic                                                 clock,
  input  logic                                                 reset,
  input_loader_if.slave                                        in_if,
  output logic [NUM_INPUTS-1:0][INTEGER_WIDTH+FRACTION_WIDTH-1:0] inputs,
  output logic                                                 inputs_ready,
  input  logic                                                 done,
  output logic                                                 busy,
  output logic                                                 frame_error
);

  localparam int WORD_W = INTEGER_WIDTH + FRACTION_WIDTH;
  localparam int CNT_W  = $clog2(NUM_INPUTS);
  // Only one of the two shifts is ever non-zero.
  localparam int SHL    = (FRACTION_WIDTH >= PIXEL_WIDTH) ? (FRACTION_WIDTH - PIXEL_WIDTH) : 0;
  localparam int SHR    = (FRACTION_WIDTH >= PIXEL_WIDTH) ? 0 : (PIXEL_WIDTH - FRACTION_WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

  localparam logic [1:0] LOADING   = 2'd0;
  localparam logic [1:0] PRESENT   = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  // Pixel -> fixed point: pixel lands in the fraction field, integer and sign stay 0.
  function automatic logic [WORD_W-1:0] pixel_to_fixed(input logic [PIXEL_WIDTH-1:0] pixel);
    logic [PIXEL_WIDTH+FRACTION_WIDTH-1:0] wide;
    wide = {{FRACTION_WIDTH{1'b0}}, pixel};
    wide = (wide << SHL) >> SHR;
    return WORD_W'(wide);
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             in_ready_r;
  logic             in_ready_s;
  logic             inputs_ready_r;
  logic             busy_r;
  logic             frame_error_r;
  logic             accept_s;
  logic             last_slot_s;
  logic             complete_s;
  logic             misaligned_s;
  logic [WORD_W-1:0] fixed_s;

  assign accept_s     = in_if.in_valid && in_ready_r;
  assign last_slot_s  = (cnt_r == LAST_IDX);
  assign complete_s   = accept_s && last_slot_s && in_if.in_last;
  // in_last early, or missing on the last slot: either way the frame is dropped.
  assign misaligned_s = accept_s && (last_slot_s != in_if.in_last);
  assign fixed_s      = pixel_to_fixed(in_if.in_data);

  assign in_if.in_ready = in_ready_r;
  assign inputs_ready   = inputs_ready_r;
  assign busy           = busy_r;
  assign frame_error    = frame_error_r;

`ifdef INPUT_LOADER_DOUBLE_BUFFER_EN
  logic [1:0][NUM_INPUTS-1:0][WORD_W-1:0] bank_r;
  logic front_r;
  logic back_full_r;
  logic back_full_s;
  logic swap_s;
  logic wr_bank_s;

  // Bank bookkeeping: LOADING fills the front bank, otherwise the back bank fills.
  always_comb begin
    swap_s = (state_r == WAIT_DONE) && done;
    if (swap_s) begin
      back_full_s = 1'b0;
    end else if (complete_s && (state_r != LOADING)) begin
      back_full_s = 1'b1;
    end else begin
      back_full_s = back_full_r;
    end
    if (state_r == LOADING) begin
      wr_bank_s = front_r;
    end else begin
      wr_bank_s = ~front_r;
    end
  end

  // Bank storage, front selector and back-full flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_r      <= {(2*NUM_INPUTS*WORD_W){1'b0}};
      front_r     <= 1'b0;
      back_full_r <= 1'b0;
    end else begin
      if (accept_s) begin
        bank_r[wr_bank_s][cnt_r] <= fixed_s;
      end
      if (swap_s) begin
        front_r <= ~front_r;
      end
      back_full_r <= back_full_s;
    end
  end

  assign inputs = bank_r[front_r];
`else
  logic [NUM_INPUTS-1:0][WORD_W-1:0] bank_r;

  // Frame storage; only written by accepted samples, which occur only in LOADING.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_r <= {(NUM_INPUTS*WORD_W){1'b0}};
    end else begin
      if (accept_s) begin
        bank_r[cnt_r] <= fixed_s;
      end
    end
  end

  assign inputs = bank_r;
`endif

  // Next-state, counter and next values of the registered outputs.
  always_comb begin
    state_s = state_r;
    if (accept_s) begin
      if (complete_s || misaligned_s) begin
        cnt_s = {CNT_W{1'b0}};
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end

    case (state_r)
      LOADING: begin
        if (complete_s) begin
          state_s = PRESENT;
        end else begin
          state_s = LOADING;
        end
      end
      PRESENT: begin
        state_s = WAIT_DONE;
      end
      WAIT_DONE: begin
`ifdef INPUT_LOADER_DOUBLE_BUFFER_EN
        // A frame finishing on the same edge as done counts as a full back bank.
        if (done) begin
          if (back_full_r || complete_s) begin
            state_s = PRESENT;
          end else begin
            state_s = LOADING;
          end
        end else begin
          state_s = WAIT_DONE;
        end
`else
        if (done) begin
          state_s = LOADING;
        end else begin
          state_s = WAIT_DONE;
        end
`endif
      end
      default: begin
        state_s = LOADING;
      end
    endcase

`ifdef INPUT_LOADER_DOUBLE_BUFFER_EN
    in_ready_s = (state_s == LOADING) || !back_full_s;
`else
    in_ready_s = (state_s == LOADING);
`endif
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= LOADING;
      cnt_r          <= {CNT_W{1'b0}};
      in_ready_r     <= 1'b1;
      inputs_ready_r <= 1'b0;
      busy_r         <= 1'b0;
      frame_error_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      in_ready_r     <= in_ready_s;
      inputs_ready_r <= (state_s == PRESENT);
      busy_r         <= (state_s != LOADING);
      frame_error_r  <= misaligned_s;
    end
  end

endmodule

// File: tb/tb_input_loader.sv
// -----------------------------------------------------------------------------
// tb_input_loader
// Directed bench for input_loader. dut_a: 4 inputs, Q8.8 words. dut_b: 4 inputs,
// 8-bit pixels into Q8.4 words (truncating conversion).
// -----------------------------------------------------------------------------
module tb_input_loader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  input_loader_if #(.PIXEL_WIDTH(8)) a_if ();
  input_loader_if #(.PIXEL_WIDTH(8)) b_if ();

  logic [3:0][15:0] a_inputs;
  logic             a_inputs_ready;
  logic             a_done;
  logic             a_busy;
  logic             a_frame_error;

  logic [3:0][11:0] b_inputs;
  logic             b_inputs_ready;
  logic             b_done;
  logic             b_busy;
  logic             b_frame_error;

  int n_checks = 0;
  int n_fail   = 0;

  input_loader #(
    .NUM_INPUTS(4), .PIXEL_WIDTH(8), .INTEGER_WIDTH(8), .FRACTION_WIDTH(8)
  ) dut_a (
    .clock(clock), .reset(reset), .in_if(a_if), .inputs(a_inputs),
    .inputs_ready(a_inputs_ready), .done(a_done), .busy(a_busy),
    .frame_error(a_frame_error)
  );

  input_loader #(
    .NUM_INPUTS(4), .PIXEL_WIDTH(8), .INTEGER_WIDTH(8), .FRACTION_WIDTH(4)
  ) dut_b (
    .clock(clock), .reset(reset), .in_if(b_if), .inputs(b_inputs),
    .inputs_ready(b_inputs_ready), .done(b_done), .busy(b_busy),
    .frame_error(b_frame_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer on dut_a; returns 1 time unit after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic l);
    chk("a_in_ready_pre_send", 64'(a_if.in_ready), 64'd1);
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.in_last  = l;
    @(posedge clock); #1;
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    b_if.in_valid = 1'b1;
    b_if.in_data  = d;
    b_if.in_last  = l;
    @(posedge clock); #1;
    b_if.in_valid = 1'b0;
    b_if.in_last  = 1'b0;
  endtask

  // From PRESENT: one edge into WAIT_DONE, then a done pulse back to LOADING.
  task automatic release_a();
    @(posedge clock); #1;
    a_done = 1'b1;
    @(posedge clock); #1;
    a_done = 1'b0;
    chk("a_release_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("a_release_busy", 64'(a_busy), 64'd0);
  endtask

  logic [63:0] held_frame;

  initial begin
    reset = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = 8'h00; a_if.in_last = 1'b0; a_done = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = 8'h00; b_if.in_last = 1'b0; b_done = 1'b0;
    #12;
    // Reset state
    chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_inputs_ready", 64'(a_inputs_ready), 64'd0);
    chk("rst_frame_error", 64'(a_frame_error), 64'd0);
    chk("rst_inputs", 64'(a_inputs), 64'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic frame: 0x00, 0x80, 0xFF, 0x01
    send_a(8'h00, 1'b0);
    send_a(8'h80, 1'b0);
    send_a(8'hFF, 1'b0);
    chk("f1_no_early_ready", 64'(a_inputs_ready), 64'd0);
    send_a(8'h01, 1'b1);
    chk("f1_inputs_ready", 64'(a_inputs_ready), 64'd1);
    chk("f1_busy", 64'(a_busy), 64'd1);
    chk("f1_in_ready_low", 64'(a_if.in_ready), 64'd0);
    chk("f1_inputs", 64'(a_inputs), 64'h0001_00FF_0080_0000);
    held_frame = 64'h0001_00FF_0080_0000;

    // done during PRESENT is ignored
    a_done = 1'b1;
    @(posedge clock); #1;
    a_done = 1'b0;
    chk("f1_ready_pulse_end", 64'(a_inputs_ready), 64'd0);
    chk("f1_busy_after_present_done", 64'(a_busy), 64'd1);

    // Source keeps offering a sample throughout WAIT_DONE
    a_if.in_valid = 1'b1; a_if.in_data = 8'h55; a_if.in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      chk("wait_in_ready_low", 64'(a_if.in_ready), 64'd0);
      chk("wait_inputs_held", 64'(a_inputs), held_frame);
    end
    a_done = 1'b1;
    @(posedge clock); #1;
    a_done = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
    chk("done_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("done_busy", 64'(a_busy), 64'd0);
    chk("done_inputs_unchanged", 64'(a_inputs), held_frame);

    // Second frame with an idle gap; in_data wiggles while in_valid is low
    send_a(8'h10, 1'b0);
    send_a(8'h20, 1'b0);
    a_if.in_data = 8'h99;
    repeat (3) @(posedge clock);
    #1;
    send_a(8'h30, 1'b0);
    send_a(8'h40, 1'b1);
    chk("f2_inputs_ready", 64'(a_inputs_ready), 64'd1);
    chk("f2_inputs", 64'(a_inputs), 64'h0040_0030_0020_0010);
    release_a();

    // in_last on the second sample
    send_a(8'h11, 1'b0);
    send_a(8'h22, 1'b1);
    chk("early_last_frame_error", 64'(a_frame_error), 64'd1);
    chk("early_last_no_ready", 64'(a_inputs_ready), 64'd0);
    chk("early_last_busy", 64'(a_busy), 64'd0);
    chk("early_last_partial", 64'(a_inputs), 64'h0040_0030_0022_0011);
    @(posedge clock); #1;
    chk("early_last_error_pulse_end", 64'(a_frame_error), 64'd0);
    send_a(8'hA0, 1'b0);
    send_a(8'hA1, 1'b0);
    send_a(8'hA2, 1'b0);
    send_a(8'hA3, 1'b1);
    chk("f3_inputs_ready", 64'(a_inputs_ready), 64'd1);
    chk("f3_frame_error", 64'(a_frame_error), 64'd0);
    chk("f3_inputs", 64'(a_inputs), 64'h00A3_00A2_00A1_00A0);
    release_a();

    // Fourth sample without in_last
    send_a(8'h01, 1'b0);
    send_a(8'h02, 1'b0);
    send_a(8'h03, 1'b0);
    send_a(8'h04, 1'b0);
    chk("missing_last_frame_error", 64'(a_frame_error), 64'd1);
    chk("missing_last_no_ready", 64'(a_inputs_ready), 64'd0);
    chk("missing_last_in_ready", 64'(a_if.in_ready), 64'd1);
    send_a(8'h05, 1'b0);
    send_a(8'h06, 1'b0);
    send_a(8'h07, 1'b0);
    send_a(8'h08, 1'b1);
    chk("f4_inputs_ready", 64'(a_inputs_ready), 64'd1);
    chk("f4_inputs", 64'(a_inputs), 64'h0008_0007_0006_0005);
    release_a();

    // done while LOADING is ignored
    a_done = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    a_done = 1'b0;
    chk("loading_done_busy", 64'(a_busy), 64'd0);
    chk("loading_done_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("loading_done_no_ready", 64'(a_inputs_ready), 64'd0);

    // Reset after two accepted samples
    send_a(8'h33, 1'b0);
    send_a(8'h44, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_inputs", 64'(a_inputs), 64'h0);
    chk("midrst_in_ready", 64'(a_if.in_ready), 64'd1);
    chk("midrst_busy", 64'(a_busy), 64'd0);
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
    send_a(8'h09, 1'b0);
    send_a(8'h0A, 1'b0);
    send_a(8'h0B, 1'b0);
    send_a(8'h0C, 1'b1);
    chk("f5_inputs_ready", 64'(a_inputs_ready), 64'd1);
    chk("f5_inputs", 64'(a_inputs), 64'h000C_000B_000A_0009);
    release_a();

    // Q8.4 instance: truncating conversion
    send_b(8'hF3, 1'b0);
    send_b(8'h08, 1'b0);
    send_b(8'h10, 1'b0);
    send_b(8'hFF, 1'b1);
    chk("b_inputs_ready", 64'(b_inputs_ready), 64'd1);
    chk("b_busy", 64'(b_busy), 64'd1);
    chk("b_frame_error", 64'(b_frame_error), 64'd0);
    chk("b_inputs", 64'(b_inputs), 64'h00F_001_000_00F);
    chk("b_word0_0xF3", 64'(b_inputs[0]), 64'h00F);
    @(posedge clock); #1;
    b_done = 1'b1;
    @(posedge clock); #1;
    b_done = 1'b0;
    chk("b_release_busy", 64'(b_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
